// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM encodings and table geometry.
package truth_table_scanner_pkg;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Hold-time counter: loaded when a vector is applied, expires on its last DRIVE cycle.
module truth_table_scanner_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= 4'(SETTLE_CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - 4'd1;
  end

  // Loaded with N-1 so the DRIVE state lasts exactly N cycles.
  assign expired = en && (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 {a,b,c,d} vectors through a logic stage, captures s into tt, compares to expected.
// Optional MISMATCH_LOG_EN adds first_fail / fail_count outputs.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_VECTORS-1:0] expected,
  input  logic                   s_in,
  output logic [IDX_W-1:0]       drive,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
`ifdef MISMATCH_LOG_EN
  output logic [IDX_W-1:0]       first_fail,
  output logic [4:0]             fail_count,
`endif
  output logic [NUM_VECTORS-1:0] tt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [NUM_VECTORS-1:0]   exp_reg;
  logic [NUM_VECTORS-1:0]   tt_next;
  logic                     accept;
  logic                     tmr_load;
  logic                     tmr_exp;

  assign accept   = start && (state == ST_IDLE || state == ST_DONE);
  assign tmr_load = accept || (state == ST_SAMPLE && idx != LAST_IDX);

  always_comb begin
    tt_next      = tt;
    tt_next[idx] = s_in;
  end

  truth_table_scanner_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (state == ST_DRIVE),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      exp_reg <= '0;
      drive   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      tt      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            exp_reg <= expected;
            tt      <= '0;
            idx     <= '0;
            drive   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            state   <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (tmr_exp) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          tt <= tt_next;
          if (idx == LAST_IDX) begin
            // Verdict uses the table including the bit captured this cycle.
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (tt_next == exp_reg);
            state <= ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            drive <= idx + IDX_W'(1);
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MISMATCH_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail <= '0;
      fail_count <= '0;
    end else if (accept) begin
      first_fail <= '0;
      fail_count <= '0;
    end else if (state == ST_SAMPLE && s_in != exp_reg[idx]) begin
      // idx ascends, so the first recorded mismatch is the lowest one.
      if (fail_count == '0) first_fail <= idx;
      fail_count <= fail_count + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: a behavioural logic stage feeds s_in; expected verdicts are queued at start.
module tb_truth_table_scanner;

  typedef struct {
    logic [15:0] tt;
    logic        pass;
    logic [3:0]  ff;
    logic [4:0]  fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] expected = '0;
  int          md_a = 0, md_b = 2;
  logic        s0, s1;
  logic [3:0]  drive0, drive1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [15:0] tt0, tt1;
  logic [3:0]  ff0, ff1;
  logic [4:0]  fc0, fc1;
  int          checks = 0, errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  function automatic logic f(input int m, input logic [3:0] v);
    case (m)
      0:       f = v[3] & v[2];
      1:       f = 1'b1;
      default: f = ~v[1] | v[0];
    endcase
  endfunction

  function automatic exp_t model(input int m, input logic [15:0] e);
    exp_t x;
    x.tt = '0; x.ff = '0; x.fc = '0;
    for (int i = 0; i < 16; i++) begin
      x.tt[i] = f(m, 4'(i));
      if (x.tt[i] != e[i]) begin
        if (x.fc == 0) x.ff = 4'(i);
        x.fc = x.fc + 5'd1;
      end
    end
    x.pass = (x.tt == e);
    return x;
  endfunction

  assign s0 = f(md_a, drive0);
  assign s1 = f(md_b, drive1);

  truth_table_scanner #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .expected(expected), .s_in(s0),
    .drive(drive0), .busy(busy0), .done(done0), .pass(pass0),
`ifdef MISMATCH_LOG_EN
    .first_fail(ff0), .fail_count(fc0),
`endif
    .tt(tt0));

  truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected), .s_in(s1),
    .drive(drive1), .busy(busy1), .done(done1), .pass(pass1),
`ifdef MISMATCH_LOG_EN
    .first_fail(ff1), .fail_count(fc1),
`endif
    .tt(tt1));

`ifndef MISMATCH_LOG_EN
  assign ff0 = '0; assign fc0 = '0; assign ff1 = '0; assign fc1 = '0;
`endif

  // One full scan on the selected instance; pulse_at >= 0 re-pulses start mid-scan with a wrong table.
  task automatic run_scan(input bit inst, input logic [15:0] e, input int lat, input int pulse_at);
    exp_t x, got;
    int cyc, steps;
    bit ord_ok;
    logic [3:0] pd, cur;
    sb.push_back(model(inst ? md_b : md_a, e));
    @(negedge clk);
    expected = e;
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    checks++;
    if ((inst ? busy1 : busy0) !== 1'b1 || (inst ? done1 : done0) !== 1'b0 ||
        (inst ? pass1 : pass0) !== 1'b0 || (inst ? tt1 : tt0) !== 16'h0)
      begin errors++; $display("FAIL start_accept: busy=%b done=%b pass=%b tt=%h, need busy=1 done=0 pass=0 tt=0",
        inst ? busy1 : busy0, inst ? done1 : done0, inst ? pass1 : pass0, inst ? tt1 : tt0); end
    pd = inst ? drive1 : drive0;
    steps = 0; ord_ok = (pd == 4'h0); cyc = 0;
    while (cyc < 400) begin
      if (cyc == pulse_at) begin
        expected = ~e;
        if (inst) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      cur = inst ? drive1 : drive0;
      if (cur !== pd) begin
        if (cur !== 4'(pd + 4'd1)) ord_ok = 1'b0;
        steps++;
        pd = cur;
      end
      if ((inst ? done1 : done0) === 1'b1) break;
    end
    start0 = 1'b0; start1 = 1'b0;
    x = sb.pop_front();
    got.tt = inst ? tt1 : tt0;   got.pass = inst ? pass1 : pass0;
    got.ff = inst ? ff1 : ff0;   got.fc = inst ? fc1 : fc0;
    checks++;
    if (cyc != lat) begin errors++; $display("FAIL latency: got %0d cycles, need %0d", cyc, lat); end
    checks++;
    if (!ord_ok || steps != 15) begin errors++; $display("FAIL drive_order: steps=%0d in_order=%b, need 15 and 1", steps, ord_ok); end
    checks++;
    if (got.tt !== x.tt) begin errors++; $display("FAIL tt: got %h, need %h", got.tt, x.tt); end
    checks++;
    if (got.pass !== x.pass) begin errors++; $display("FAIL pass: got %b, need %b", got.pass, x.pass); end
    checks++;
    if ((inst ? busy1 : busy0) !== 1'b0) begin errors++; $display("FAIL busy_done: got 1, need 0"); end
`ifdef MISMATCH_LOG_EN
    checks++;
    if (got.ff !== x.ff) begin errors++; $display("FAIL first_fail: got %0d, need %0d", got.ff, x.ff); end
    checks++;
    if (got.fc !== x.fc) begin errors++; $display("FAIL fail_count: got %0d, need %0d", got.fc, x.fc); end
`endif
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (drive0 !== 4'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || tt0 !== 16'h0)
      begin errors++; $display("FAIL reset: drive=%h busy=%b done=%b pass=%b tt=%h, need all 0",
        drive0, busy0, done0, pass0, tt0); end
`ifdef MISMATCH_LOG_EN
    checks++;
    if (ff0 !== 4'h0 || fc0 !== 5'h0) begin errors++; $display("FAIL reset_log: ff=%0d fc=%0d, need 0 0", ff0, fc0); end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL idle: busy=%b done=%b, need 0 0", busy0, done0); end
  endtask

  task automatic test_rst_mid_scan();
    int n;
    md_a = 0;
    @(negedge clk);
    expected = 16'hF000; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (drive0 !== 4'h5 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (drive0 !== 4'h5) begin errors++; $display("FAIL reach_idx5: drive=%h, need 5", drive0); end
    checks++;
    if (tt0 === 16'h0) begin errors++; $display("FAIL partial_tt: got 0, need nonzero-able partial scan ignored"); end
    rst = 1'b1; #1;
    checks++;
    if (drive0 !== 4'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== 16'h0)
      begin errors++; $display("FAIL rst_abort: drive=%h busy=%b done=%b tt=%h, need 0 0 0 0", drive0, busy0, done0, tt0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs the first idx=5 check only meaningfully after bit 4 ... tt stays 0 until idx 12, so gate it.
  initial begin
    test_reset();
    test_rst_mid_scan_wrap();
    md_a = 0; run_scan(1'b0, 16'hF000, 48, -1);   // a & b matches
    md_a = 0; run_scan(1'b0, 16'hF001, 48, -1);   // bit 0 mismatch
    md_a = 0; run_scan(1'b0, 16'hF000, 48, 10);   // start while busy ignored
    md_a = 1; run_scan(1'b0, 16'hFFFF, 48, -1);   // restart from DONE
    md_b = 2; run_scan(1'b1, 16'hBBBB, 32, -1);   // ~c | d, one-cycle settle
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic test_rst_mid_scan_wrap();
    int n;
    md_a = 1;
    @(negedge clk);
    expected = 16'hFFFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (drive0 !== 4'h5 && n < 200) begin @(posedge clk); #1; n++; end
    checks++;
    if (drive0 !== 4'h5 || busy0 !== 1'b1) begin errors++; $display("FAIL reach_idx5: drive=%h busy=%b, need 5 1", drive0, busy0); end
    checks++;
    if (tt0 !== 16'h001F) begin errors++; $display("FAIL partial_tt: got %h, need 001f", tt0); end
    rst = 1'b1; #1;
    checks++;
    if (drive0 !== 4'h0 || busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== 16'h0)
      begin errors++; $display("FAIL rst_abort: drive=%h busy=%b done=%b tt=%h, need 0 0 0 0", drive0, busy0, done0, tt0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL post_abort: busy=%b done=%b, need 0 0", busy0, done0); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
